// File: rtl/ir_tx.sv
// NEC-style IR transmitter: sends a 32-bit word as lead mark/space, 32 pulse-distance
// bits MSB first, a stop mark and a guard gap, as an envelope and a carrier-gated LED drive.
module ir_tx #(
  parameter int CLK_HZ       = 50_000_000,
  parameter int TICK_DIV     = CLK_HZ / 1_000_000,
  parameter int CARRIER_DIV  = 1316,
  parameter int CARRIER_HIGH = 438,
  parameter int T_LEAD_MARK  = 9000,
  parameter int T_LEAD_SPACE = 4500,
  parameter int T_BIT_MARK   = 560,
  parameter int T_ZERO_SPACE = 560,
  parameter int T_ONE_SPACE  = 1690,
  parameter int T_STOP_MARK  = 560,
  parameter int T_GAP        = 2000,
  parameter int SEG_W        = 14
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_start,
  input  logic [31:0] i_data,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_ir_env,
  output logic        o_ir_tx
);

  localparam int CYC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int PH_W  = (CARRIER_DIV > 1) ? $clog2(CARRIER_DIV) : 1;

  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(TICK_DIV - 1);
  localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(CARRIER_DIV - 1);
  localparam logic [PH_W:0]    PH_HIGH  = (PH_W + 1)'(CARRIER_HIGH);

  // Last tick index of each segment; a segment ends on the final clock of that tick.
  localparam logic [SEG_W-1:0] D_LEAD_MARK  = SEG_W'(T_LEAD_MARK - 1);
  localparam logic [SEG_W-1:0] D_LEAD_SPACE = SEG_W'(T_LEAD_SPACE - 1);
  localparam logic [SEG_W-1:0] D_BIT_MARK   = SEG_W'(T_BIT_MARK - 1);
  localparam logic [SEG_W-1:0] D_ZERO_SPACE = SEG_W'(T_ZERO_SPACE - 1);
  localparam logic [SEG_W-1:0] D_ONE_SPACE  = SEG_W'(T_ONE_SPACE - 1);
  localparam logic [SEG_W-1:0] D_STOP_MARK  = SEG_W'(T_STOP_MARK - 1);
  localparam logic [SEG_W-1:0] D_GAP        = SEG_W'(T_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_LEAD_MARK  = 3'd1,
    S_LEAD_SPACE = 3'd2,
    S_BIT_MARK   = 3'd3,
    S_BIT_SPACE  = 3'd4,
    S_STOP_MARK  = 3'd5,
    S_GAP        = 3'd6
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic [31:0]       r_shift;
  logic [4:0]        r_bit_cnt;
  logic [CYC_W-1:0]  r_cyc;
  logic [SEG_W-1:0]  r_seg;
  logic [PH_W-1:0]   r_phase;
  logic [PH_W-1:0]   w_phase_next;
  logic [SEG_W-1:0]  w_dur;
  logic              w_seg_end;
  logic              w_seg_start;
  logic              w_load;
  logic              w_shift;
  logic              w_mark_next;
  logic              w_carrier;
  logic              r_busy;
  logic              r_done;
  logic              r_env;
  logic              r_tx;

  // Duration of the current segment; bit spaces depend on the bit being sent.
  always_comb begin
    w_dur = '0;
    case (r_state)
      S_LEAD_MARK:  w_dur = D_LEAD_MARK;
      S_LEAD_SPACE: w_dur = D_LEAD_SPACE;
      S_BIT_MARK:   w_dur = D_BIT_MARK;
      S_BIT_SPACE:  w_dur = r_shift[31] ? D_ONE_SPACE : D_ZERO_SPACE;
      S_STOP_MARK:  w_dur = D_STOP_MARK;
      S_GAP:        w_dur = D_GAP;
      default:      w_dur = '0;
    endcase
  end

  assign w_seg_end = (r_cyc == CYC_LAST) && (r_seg == w_dur);

  // Next-state logic and shift/load controls.
  always_comb begin
    w_next  = r_state;
    w_load  = 1'b0;
    w_shift = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_next = S_LEAD_MARK;
          w_load = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_LEAD_MARK: begin
        if (w_seg_end) w_next = S_LEAD_SPACE;
        else           w_next = S_LEAD_MARK;
      end
      S_LEAD_SPACE: begin
        if (w_seg_end) w_next = S_BIT_MARK;
        else           w_next = S_LEAD_SPACE;
      end
      S_BIT_MARK: begin
        if (w_seg_end) w_next = S_BIT_SPACE;
        else           w_next = S_BIT_MARK;
      end
      S_BIT_SPACE: begin
        if (w_seg_end) begin
          w_shift = 1'b1;
          if (r_bit_cnt == 5'd31) w_next = S_STOP_MARK;
          else                    w_next = S_BIT_MARK;
        end else begin
          w_next = S_BIT_SPACE;
        end
      end
      S_STOP_MARK: begin
        if (w_seg_end) w_next = S_GAP;
        else           w_next = S_STOP_MARK;
      end
      S_GAP: begin
        if (w_seg_end) w_next = S_IDLE;
        else           w_next = S_GAP;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Every transition is a segment boundary, so it doubles as the timer restart.
  assign w_seg_start = (w_next != r_state);

  // State register, shift register and bit counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_shift   <= 32'd0;
      r_bit_cnt <= 5'd0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_shift   <= i_data;
        r_bit_cnt <= 5'd0;
      end else if (w_shift) begin
        r_shift   <= {r_shift[30:0], 1'b0};
        r_bit_cnt <= r_bit_cnt + 5'd1;
      end else begin
        r_shift   <= r_shift;
        r_bit_cnt <= r_bit_cnt;
      end
    end
  end

  // Microsecond tick prescaler and per-segment tick counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cyc <= '0;
      r_seg <= '0;
    end else if (w_seg_start || (w_next == S_IDLE)) begin
      r_cyc <= '0;
      r_seg <= '0;
    end else if (r_cyc == CYC_LAST) begin
      r_cyc <= '0;
      r_seg <= r_seg + SEG_W'(1);
    end else begin
      r_cyc <= r_cyc + CYC_W'(1);
      r_seg <= r_seg;
    end
  end

  // Carrier phase for the upcoming cycle; realigned at each mark entry.
  always_comb begin
    w_mark_next = (w_next == S_LEAD_MARK) || (w_next == S_BIT_MARK) ||
                  (w_next == S_STOP_MARK);
    if ((w_next == S_IDLE) || (w_mark_next && w_seg_start)) begin
      w_phase_next = '0;
    end else if (r_phase == PH_LAST) begin
      w_phase_next = '0;
    end else begin
      w_phase_next = r_phase + PH_W'(1);
    end
  end

  assign w_carrier = ({1'b0, w_phase_next} < PH_HIGH);

  // Carrier phase register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_phase <= '0;
    end else begin
      r_phase <= w_phase_next;
    end
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_env  <= 1'b0;
      r_tx   <= 1'b0;
    end else begin
      r_busy <= (w_next != S_IDLE);
      r_done <= (r_state == S_GAP) && w_seg_end;
      r_env  <= w_mark_next;
      r_tx   <= w_mark_next && w_carrier;
    end
  end

  assign o_busy   = r_busy;
  assign o_done   = r_done;
  assign o_ir_env = r_env;
  assign o_ir_tx  = r_tx;

endmodule
